// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the EX-stage divide sequencer: op encoding, FSM states
// and small op-decode helpers.
package div_seq_ctrl_pkg;

    localparam logic [1:0] OP_DIV_W  = 2'd0;
    localparam logic [1:0] OP_MOD_W  = 2'd1;
    localparam logic [1:0] OP_DIV_WU = 2'd2;
    localparam logic [1:0] OP_MOD_WU = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == OP_DIV_W) || (op == OP_MOD_W);
    endfunction

    function automatic logic is_rem_op(input logic [1:0] op);
        return (op == OP_MOD_W) || (op == OP_MOD_WU);
    endfunction

endpackage

// File: rtl/div_chan_issue.sv
// One AXI-stream operand channel: registered tvalid plus a sticky handshake-done bit.
module div_chan_issue
    import div_seq_ctrl_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic kill,
    input  logic tready,
    output logic tvalid,
    output logic done,
    output logic hs
);

    logic tvalid_q, tvalid_d;
    logic done_q, done_d;

    // Next-state for the channel valid and its done flag
    always_comb begin
        hs       = tvalid_q & tready;
        tvalid_d = tvalid_q;
        done_d   = done_q;
        if (kill) begin
            tvalid_d = 1'b0;
            done_d   = 1'b0;
        end else if (start) begin
            tvalid_d = 1'b1;
            done_d   = 1'b0;
        end else if (hs) begin
            tvalid_d = 1'b0;
            done_d   = 1'b1;
        end else begin
            tvalid_d = tvalid_q;
            done_d   = done_q;
        end
    end

    // Channel state registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tvalid_q <= tvalid_d;
            done_q   <= done_d;
        end
    end

    assign tvalid = tvalid_q;
    assign done   = done_q;

endmodule

// File: rtl/div_seq_ctrl.sv
// EX-stage divide sequencer: issues operands to the signed/unsigned divider, drains
// flushed operations and holds the result for EX. Optional result cache: DIV_RESULT_CACHE_EN.
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [DW-1:0]   req_src1,
    input  logic [DW-1:0]   req_src2,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [DW-1:0]   resp_result,
    output logic            busy,
    output logic [DW-1:0]   div_dividend,
    output logic [DW-1:0]   div_divisor,
    output logic            sdiv_dividend_tvalid,
    input  logic            sdiv_dividend_tready,
    output logic            sdiv_divisor_tvalid,
    input  logic            sdiv_divisor_tready,
    input  logic            sdiv_dout_tvalid,
    input  logic [2*DW-1:0] sdiv_dout_tdata,
    output logic            udiv_dividend_tvalid,
    input  logic            udiv_dividend_tready,
    output logic            udiv_divisor_tvalid,
    input  logic            udiv_divisor_tready,
    input  logic            udiv_dout_tvalid,
    input  logic [2*DW-1:0] udiv_dout_tdata
);

    function automatic logic [DW-1:0] sel_result(input logic [1:0] op, input logic [2*DW-1:0] data);
        return is_rem_op(op) ? data[DW-1:0] : data[2*DW-1:DW];
    endfunction

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [DW-1:0]   src1_q, src1_d, src2_q, src2_d;
    logic            cancel_q, cancel_d;
    logic            resp_valid_q, resp_valid_d;
    logic [DW-1:0]   resp_result_q, resp_result_d;

    logic            sel_signed_s, chan_start_s, chan_kill_s;
    logic            dvd_tvalid_s, dvd_done_s, dvd_hs_s;
    logic            dvs_tvalid_s, dvs_done_s, dvs_hs_s;
    logic            dout_v_s, any_hs_s, all_done_s;
    logic [2*DW-1:0] dout_data_s;
    logic            cache_hit_s;
    logic [DW-1:0]   cache_res_s;

    assign sel_signed_s = is_signed_op(op_q);
    assign dout_v_s     = sel_signed_s ? sdiv_dout_tvalid : udiv_dout_tvalid;
    assign dout_data_s  = sel_signed_s ? sdiv_dout_tdata : udiv_dout_tdata;

    div_chan_issue u_dvd (
        .clk    (clk),
        .resetn (resetn),
        .start  (chan_start_s),
        .kill   (chan_kill_s),
        .tready (sel_signed_s ? sdiv_dividend_tready : udiv_dividend_tready),
        .tvalid (dvd_tvalid_s),
        .done   (dvd_done_s),
        .hs     (dvd_hs_s)
    );

    div_chan_issue u_dvs (
        .clk    (clk),
        .resetn (resetn),
        .start  (chan_start_s),
        .kill   (chan_kill_s),
        .tready (sel_signed_s ? sdiv_divisor_tready : udiv_divisor_tready),
        .tvalid (dvs_tvalid_s),
        .done   (dvs_done_s),
        .hs     (dvs_hs_s)
    );

    assign any_hs_s   = dvd_done_s | dvs_done_s | dvd_hs_s | dvs_hs_s;
    assign all_done_s = (dvd_done_s | dvd_hs_s) & (dvs_done_s | dvs_hs_s);

`ifdef DIV_RESULT_CACHE_EN
    logic            cache_valid_q, cache_valid_d;
    logic            cache_signed_q, cache_signed_d;
    logic [DW-1:0]   cache_src1_q, cache_src1_d, cache_src2_q, cache_src2_d;
    logic [2*DW-1:0] cache_data_q, cache_data_d;
    logic            cache_wr_s;

    // Only genuine WAIT->DONE captures fill the entry; drained results never do
    assign cache_wr_s = (state_q == WAIT) && dout_v_s && !flush;

    // Cache lookup and fill
    always_comb begin
        cache_hit_s    = cache_valid_q && (cache_signed_q == is_signed_op(req_op)) &&
                         (cache_src1_q == req_src1) && (cache_src2_q == req_src2);
        cache_res_s    = sel_result(req_op, cache_data_q);
        cache_valid_d  = cache_valid_q;
        cache_signed_d = cache_signed_q;
        cache_src1_d   = cache_src1_q;
        cache_src2_d   = cache_src2_q;
        cache_data_d   = cache_data_q;
        if (cache_wr_s) begin
            cache_valid_d  = 1'b1;
            cache_signed_d = sel_signed_s;
            cache_src1_d   = src1_q;
            cache_src2_d   = src2_q;
            cache_data_d   = dout_data_s;
        end else begin
            cache_valid_d  = cache_valid_q;
        end
    end

    // Cache entry registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cache_valid_q  <= 1'b0;
            cache_signed_q <= 1'b0;
            cache_src1_q   <= '0;
            cache_src2_q   <= '0;
            cache_data_q   <= '0;
        end else begin
            cache_valid_q  <= cache_valid_d;
            cache_signed_q <= cache_signed_d;
            cache_src1_q   <= cache_src1_d;
            cache_src2_q   <= cache_src2_d;
            cache_data_q   <= cache_data_d;
        end
    end
`else
    assign cache_hit_s = 1'b0;
    assign cache_res_s = '0;
`endif

    // Sequencer next-state logic
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        src1_d        = src1_q;
        src2_d        = src2_q;
        cancel_d      = cancel_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        chan_start_s  = 1'b0;
        chan_kill_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    op_d     = req_op;
                    src1_d   = req_src1;
                    src2_d   = req_src2;
                    cancel_d = 1'b0;
                    if (cache_hit_s) begin
                        state_d       = DONE;
                        resp_valid_d  = 1'b1;
                        resp_result_d = cache_res_s;
                    end else begin
                        state_d      = ISSUE;
                        chan_start_s = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                // Once any operand is handed over the divider must see the whole pair
                if (flush && !any_hs_s) begin
                    chan_kill_s = 1'b1;
                    cancel_d    = 1'b0;
                    state_d     = IDLE;
                end else if (all_done_s) begin
                    state_d  = (cancel_q || flush) ? DRAIN : WAIT;
                    cancel_d = 1'b0;
                end else if (flush) begin
                    cancel_d = 1'b1;
                end else begin
                    cancel_d = cancel_q;
                end
            end
            WAIT: begin
                if (dout_v_s) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        state_d       = DONE;
                        resp_valid_d  = 1'b1;
                        resp_result_d = sel_result(op_q, dout_data_s);
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end else begin
                    state_d = WAIT;
                end
            end
            DRAIN: begin
                if (dout_v_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                if (flush || resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d      = IDLE;
                chan_kill_s  = 1'b1;
                cancel_d     = 1'b0;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= IDLE;
            op_q          <= 2'd0;
            src1_q        <= '0;
            src2_q        <= '0;
            cancel_q      <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            src1_q        <= src1_d;
            src2_q        <= src2_d;
            cancel_q      <= cancel_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
        end
    end

    assign req_ready            = (state_q == IDLE);
    assign busy                 = (state_q != IDLE);
    assign resp_valid           = resp_valid_q;
    assign resp_result          = resp_result_q;
    assign div_dividend         = src1_q;
    assign div_divisor          = src2_q;
    assign sdiv_dividend_tvalid = dvd_tvalid_s & sel_signed_s;
    assign sdiv_divisor_tvalid  = dvs_tvalid_s & sel_signed_s;
    assign udiv_dividend_tvalid = dvd_tvalid_s & ~sel_signed_s;
    assign udiv_divisor_tvalid  = dvs_tvalid_s & ~sel_signed_s;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: behavioural signed/unsigned dividers, directed requests,
// and a result scoreboard popped by an independent response monitor.
module tb_div_seq_ctrl;
    localparam int DW  = 32;
    localparam int LAT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            resetn, req_valid, req_ready, flush, resp_valid, resp_ready, busy;
    logic [1:0]      req_op;
    logic [DW-1:0]   req_src1, req_src2, resp_result, div_dividend, div_divisor;
    logic            sdiv_dividend_tvalid, sdiv_dividend_tready, sdiv_divisor_tvalid, sdiv_divisor_tready;
    logic            udiv_dividend_tvalid, udiv_dividend_tready, udiv_divisor_tvalid, udiv_divisor_tready;
    logic            sdiv_dout_tvalid, udiv_dout_tvalid;
    logic [2*DW-1:0] sdiv_dout_tdata, udiv_dout_tdata;

    div_seq_ctrl #(.DW(DW)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .busy(busy), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .sdiv_dividend_tvalid(sdiv_dividend_tvalid), .sdiv_dividend_tready(sdiv_dividend_tready),
        .sdiv_divisor_tvalid(sdiv_divisor_tvalid), .sdiv_divisor_tready(sdiv_divisor_tready),
        .sdiv_dout_tvalid(sdiv_dout_tvalid), .sdiv_dout_tdata(sdiv_dout_tdata),
        .udiv_dividend_tvalid(udiv_dividend_tvalid), .udiv_dividend_tready(udiv_dividend_tready),
        .udiv_divisor_tvalid(udiv_divisor_tvalid), .udiv_divisor_tready(udiv_divisor_tready),
        .udiv_dout_tvalid(udiv_dout_tvalid), .udiv_dout_tdata(udiv_dout_tdata)
    );

    // Behavioural dividers: accept both operands, answer LAT-ish cycles later
    logic [DW-1:0] s_a, s_b, u_a, u_b;
    logic          s_ga, s_gb, s_run, u_ga, u_gb, u_run;
    int            s_cnt, u_cnt;

    always @(posedge clk) begin
        sdiv_dout_tvalid <= 1'b0;
        if (!resetn) begin
            s_ga <= 1'b0; s_gb <= 1'b0; s_run <= 1'b0; s_cnt <= 0;
            sdiv_dout_tdata <= '0;
        end else begin
            if (sdiv_dividend_tvalid && sdiv_dividend_tready) begin s_ga <= 1'b1; s_a <= div_dividend; end
            if (sdiv_divisor_tvalid && sdiv_divisor_tready) begin s_gb <= 1'b1; s_b <= div_divisor; end
            if (s_ga && s_gb && !s_run) begin s_run <= 1'b1; s_cnt <= LAT - 2; s_ga <= 1'b0; s_gb <= 1'b0; end
            if (s_run) begin
                if (s_cnt == 0) begin
                    sdiv_dout_tvalid <= 1'b1;
                    sdiv_dout_tdata  <= {DW'($signed(s_a) / $signed(s_b)), DW'($signed(s_a) % $signed(s_b))};
                    s_run <= 1'b0;
                end else begin
                    s_cnt <= s_cnt - 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        udiv_dout_tvalid <= 1'b0;
        if (!resetn) begin
            u_ga <= 1'b0; u_gb <= 1'b0; u_run <= 1'b0; u_cnt <= 0;
            udiv_dout_tdata <= '0;
        end else begin
            if (udiv_dividend_tvalid && udiv_dividend_tready) begin u_ga <= 1'b1; u_a <= div_dividend; end
            if (udiv_divisor_tvalid && udiv_divisor_tready) begin u_gb <= 1'b1; u_b <= div_divisor; end
            if (u_ga && u_gb && !u_run) begin u_run <= 1'b1; u_cnt <= LAT - 2; u_ga <= 1'b0; u_gb <= 1'b0; end
            if (u_run) begin
                if (u_cnt == 0) begin
                    udiv_dout_tvalid <= 1'b1;
                    udiv_dout_tdata  <= {u_a / u_b, u_a % u_b};
                    u_run <= 1'b0;
                end else begin
                    u_cnt <= u_cnt - 1;
                end
            end
        end
    end

    // Cycle counters of asserted valids, read as before/after differences
    int cnt_sdvd = 0, cnt_sdvs = 0, cnt_udvd = 0, cnt_udvs = 0, cnt_sdout = 0;
    always @(negedge clk) begin
        cnt_sdvd  <= cnt_sdvd  + int'(sdiv_dividend_tvalid);
        cnt_sdvs  <= cnt_sdvs  + int'(sdiv_divisor_tvalid);
        cnt_udvd  <= cnt_udvd  + int'(udiv_dividend_tvalid);
        cnt_udvs  <= cnt_udvs  + int'(udiv_divisor_tvalid);
        cnt_sdout <= cnt_sdout + int'(sdiv_dout_tvalid);
    end

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] sb[$];

    // Response monitor: every consumed result must match the oldest expectation
    always @(negedge clk) begin
        if (resetn && resp_valid && resp_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL resp_unexpected: got 0x%08h, none expected", resp_result);
            end else if (resp_result !== sb[0]) begin
                miscompares++;
                $display("FAIL resp_result: got 0x%08h expected 0x%08h", resp_result, sb[0]);
                void'(sb.pop_front());
            end else begin
                void'(sb.pop_front());
            end
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin tick(); n++; end
        if (n >= 100) check("send_timeout", 32'd1, 32'd0);
        req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while ((busy || resp_valid) && n < 200) begin tick(); n++; end
        if (n >= 200) check("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int d0, d1, d2, d3, n;
        resetn = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_src1 = '0; req_src2 = '0;
        flush = 1'b0; resp_ready = 1'b1;
        sdiv_dividend_tready = 1'b1; sdiv_divisor_tready = 1'b1;
        udiv_dividend_tready = 1'b1; udiv_divisor_tready = 1'b1;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_result", resp_result, 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_tvalids", 32'({sdiv_dividend_tvalid, sdiv_divisor_tvalid, udiv_dividend_tvalid, udiv_divisor_tvalid}), 32'd0);
        resetn = 1'b1;
        tick();

        // div.w -7 / 2
        d0 = cnt_sdvd; d1 = cnt_sdvs; d2 = cnt_udvd + cnt_udvs;
        sb.push_back(32'hFFFF_FFFD);
        send(2'd0, 32'hFFFF_FFF9, 32'd2);
        n = 0;
        while (!sdiv_dout_tvalid && n < 40) begin tick(); n++; end
        check("t1_dout_seen", 32'(n < 40), 32'd1);
        tick();
        check("t1_resp_valid_lat", 32'(resp_valid), 32'd1);
        wait_idle();
        check("t1_sdvd_cycles", 32'(cnt_sdvd - d0), 32'd1);
        check("t1_sdvs_cycles", 32'(cnt_sdvs - d1), 32'd1);
        check("t1_udiv_cycles", 32'(cnt_udvd + cnt_udvs - d2), 32'd0);

        // mod.wu 0xFFFFFFFF % 10 with a slow divisor channel
        d0 = cnt_udvd; d1 = cnt_udvs; d2 = cnt_sdvd + cnt_sdvs;
        udiv_divisor_tready = 1'b0;
        sb.push_back(32'd5);
        send(2'd3, 32'hFFFF_FFFF, 32'd10);
        check("t2_both_valid", 32'({udiv_dividend_tvalid, udiv_divisor_tvalid}), 32'd3);
        tick();
        check("t2_dvd_dropped", 32'({udiv_dividend_tvalid, udiv_divisor_tvalid}), 32'd1);
        tick(); tick();
        udiv_divisor_tready = 1'b1;
        tick();
        check("t2_dvs_dropped", 32'(udiv_divisor_tvalid), 32'd0);
        wait_idle();
        check("t2_udvd_cycles", 32'(cnt_udvd - d0), 32'd1);
        check("t2_udvs_cycles", 32'(cnt_udvs - d1), 32'd4);
        check("t2_sdiv_cycles", 32'(cnt_sdvd + cnt_sdvs - d2), 32'd0);

        // flush in WAIT, then div.wu 100/7 must wait for the drain
        send(2'd0, 32'd10, 32'd3);
        tick();
        check("t3_busy_wait", 32'(busy), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        d3 = cnt_sdout;
        sb.push_back(32'd14);
        req_valid = 1'b1; req_op = 2'd2; req_src1 = 32'd100; req_src2 = 32'd7;
        check("t3_drain_req_ready", 32'(req_ready), 32'd0);
        n = 0;
        while (!req_ready && n < 40) begin tick(); n++; end
        check("t3_drained_first", 32'(cnt_sdout - d3), 32'd1);
        tick();
        req_valid = 1'b0;
        wait_idle();

        // flush on the first ISSUE cycle with nothing accepted
        sdiv_dividend_tready = 1'b0; sdiv_divisor_tready = 1'b0;
        d3 = cnt_sdout;
        send(2'd0, 32'd9, 32'd3);
        check("t4_issue_valid", 32'(sdiv_dividend_tvalid), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_tvalids_off", 32'({sdiv_dividend_tvalid, sdiv_divisor_tvalid}), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        repeat (15) tick();
        check("t4_no_dout", 32'(cnt_sdout - d3), 32'd0);
        sdiv_dividend_tready = 1'b1; sdiv_divisor_tready = 1'b1;

        // DONE held five cycles, then flushed alongside a new request
        resp_ready = 1'b0;
        send(2'd2, 32'd20, 32'd4);
        n = 0;
        while (!resp_valid && n < 40) begin tick(); n++; end
        check("t5_resp_seen", 32'(n < 40), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("t5_result_stable", resp_result, 32'd5);
            tick();
        end
        flush = 1'b1; req_valid = 1'b1; req_op = 2'd0; req_src1 = 32'd7; req_src2 = 32'd7;
        tick();
        check("t5_resp_dropped", 32'(resp_valid), 32'd0);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        check("t5_req_ignored", 32'(busy), 32'd0);
        resp_ready = 1'b1;
        tick();

        // div.w then mod.w on the same operands
        sb.push_back(32'd8);
        send(2'd0, 32'd50, 32'd6);
        wait_idle();
        d0 = cnt_sdvd + cnt_sdvs + cnt_udvd + cnt_udvs;
        sb.push_back(32'd2);
        send(2'd1, 32'd50, 32'd6);
`ifdef DIV_RESULT_CACHE_EN
        check("t6_cache_hit_valid", 32'(resp_valid), 32'd1);
`endif
        wait_idle();
`ifdef DIV_RESULT_CACHE_EN
        check("t6_cache_no_tvalid", 32'(cnt_sdvd + cnt_sdvs + cnt_udvd + cnt_udvs - d0), 32'd0);
`endif

        repeat (3) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Sequences the EX-stage 32-bit divide datapath: accepts one div/mod request, drives the operand handshake into the signed or unsigned AXI-stream divider unit, waits for the result and holds it until EX consumes it.
- Handles pipeline flush at any point. An in-flight divider operation cannot be cancelled, so its result is drained and discarded before the next request is accepted.

Parameters:
- DW, 32, operand width; divider output width is 2*DW.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- req_valid  in  1  EX presents a divide request
- req_ready  out  1  controller can accept a request
- req_op  in  2  0=div.w, 1=mod.w, 2=div.wu, 3=mod.wu
- req_src1  in  DW  dividend
- req_src2  in  DW  divisor
- flush  in  1  exception/ertn flush; kills the current request
- resp_valid  out  1  result available
- resp_ready  in  1  EX consumes the result
- resp_result  out  DW  quotient or remainder
- busy  out  1  state != IDLE
- div_dividend  out  DW  latched dividend, shared by both units
- div_divisor  out  DW  latched divisor, shared by both units
- sdiv_dividend_tvalid, sdiv_divisor_tvalid  out  1 each  signed-unit operand valids
- sdiv_dividend_tready, sdiv_divisor_tready  in  1 each  signed-unit operand readies
- sdiv_dout_tvalid  in  1  signed-unit result valid
- sdiv_dout_tdata  in  2*DW  {quotient, remainder}
- udiv_*  same six signals for the unsigned unit

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE; all tvalids=0; resp_valid=0; resp_result=0; latched operands and op=0; cancel flag=0.
- IDLE: req_ready=1.
  - req_valid & ~flush: latch op/src1/src2, go to ISSUE.
  - req_valid & flush: ignored.
- ISSUE:
  - Both tvalids of the selected unit (signed for op 0/1, unsigned for op 2/3) are registered high on entry. The other unit's valids stay 0.
  - Each channel's tvalid drops independently the cycle after its own tvalid&tready. A handshake-done bit is kept per channel.
  - Both channels done: go to WAIT, or to DRAIN if cancelled.
  - flush before any channel has handshaken: all tvalids drop next cycle, go to IDLE.
  - flush after one channel has handshaken: set cancel and finish the remaining channel. The divider must never be left with a half-issued operation.
- WAIT:
  - On the selected dout_tvalid, capture the result: quotient = tdata[2*DW-1:DW] for op 0/2; remainder = tdata[DW-1:0] for op 1/3. Go to DONE.
  - flush: go to DRAIN. A flush in the same cycle as dout_tvalid also goes to IDLE and discards the result.
- DRAIN: req_ready=0. Wait for the selected dout_tvalid, discard it, go to IDLE.
- DONE:
  - resp_valid=1 and resp_result is stable.
  - resp_ready: go to IDLE.
  - flush: go to IDLE, resp_valid=0 next cycle. flush takes priority over resp_ready.
- Timing:
  - With tready=1, tvalid is high for exactly one cycle.
  - resp_valid rises one cycle after dout_tvalid is sampled.
  - A new request is accepted no earlier than the cycle after the DONE→IDLE transition.
- Divide-by-zero and overflow (INT_MIN/-1): the divider output passes through unmodified. No exception is raised.
- The dout_tvalid of the non-selected unit is ignored in every state.

Optional Feature:
- Macro DIV_RESULT_CACHE_EN.
- Defined:
  - Keeps one entry {valid, signed, src1, src2, 2*DW result}, written on every WAIT→DONE capture.
  - A request in IDLE whose signedness, src1 and src2 all match a valid entry goes straight to DONE. resp_valid is high the next cycle and the quotient/remainder is selected per the new op, so mod.w after div.w on the same operands hits.
  - Drained (cancelled) results are never written. The entry is cleared only by reset.
- Undefined: no entry; every request goes through ISSUE.

Decomposition:
- Shared package holds the op encoding constants (OP_DIV_W, OP_MOD_W, OP_DIV_WU, OP_MOD_WU) and the state enum (IDLE, ISSUE, WAIT, DRAIN, DONE).
- One sub-module: div_chan_issue, a per-channel tvalid register plus handshake-done bit. It is instantiated twice, for dividend and divisor.

Test Plan:
- div.w src1=-7 (0xFFFFFFF9), src2=2, tready=1, 8-cycle divider latency → sdiv tvalids high 1 cycle, resp_result=0xFFFFFFFD, resp_valid 1 cycle after dout_tvalid, udiv valids stay 0.
- mod.wu src1=0xFFFFFFFF, src2=10, divisor_tready delayed 3 cycles past dividend_tready → dividend_tvalid drops first, divisor_tvalid holds until its handshake, resp_result=5.
- div.w issued, flush in WAIT, then new req div.wu 100/7 → req_ready=0 until stale dout_tvalid is drained, then second result=14 with no stale value leaking.
- flush in ISSUE cycle 1 with both treadys=0 → tvalids 0 next cycle, state IDLE, no drain, busy=0.
- DONE with resp_ready=0 for 5 cycles then flush → resp_result stable for 5 cycles, resp_valid drops after the flush, a request in the same cycle as the flush is not accepted.
- DIV_RESULT_CACHE_EN: div.w 50/6 then mod.w 50/6 → second resp_valid 1 cycle after accept, result=2, no tvalid asserted.
